// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: decode stage between fetch and execute.
// Register file with write-back port, field decoder, load-use stall detection,
// two-word immediate sequencing, branch resolution with a post-branch flush
// window, and a registered ID/EX entry with valid/ready handshakes.
// Optional build macro: DEC_WB_BYPASS_EN (same-cycle write-back bypass on reads).
module decode_stage_pipe #(
    parameter int WIDTH        = 16,
    parameter int NREGS        = 8,
    parameter int PCW          = 32,
    parameter int FLUSH_CYCLES = 2,
    localparam int AW          = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] instr,
    input  logic [PCW-1:0]   in_pc,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             ex_load_pending,
    input  logic [AW-1:0]    ex_load_rd,
    input  logic [2:0]       ccr,
    input  logic             ext_flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_op1,
    output logic [WIDTH-1:0] out_op2,
    output logic [WIDTH-1:0] out_imm,
    output logic [AW-1:0]    out_rs,
    output logic [AW-1:0]    out_rd,
    output logic [4:0]       out_aluop,
    output logic             out_regwr,
    output logic             out_memr,
    output logic             out_memwr,
    output logic             out_ldm,
    output logic [PCW-1:0]   out_pc,
    output logic             branch_taken,
    output logic [PCW-1:0]   branch_target
);

    localparam int CW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        S_DECODE,
        S_IMM_WAIT,
        S_FLUSH
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] op1;
        logic [WIDTH-1:0] op2;
        logic [WIDTH-1:0] imm;
        logic [AW-1:0]    rs;
        logic [AW-1:0]    rd;
        logic [4:0]       aluop;
        logic             regwr;
        logic             memr;
        logic             memwr;
        logic             ldm;
        logic [PCW-1:0]   pc;
    } entry_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    entry_t           ent_q, ent_d;
    entry_t           pend_q, pend_d;
    logic             br_taken_q, br_taken_d;
    logic [PCW-1:0]   br_target_q, br_target_d;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    logic [4:0]       opcode;
    logic [AW-1:0]    rs;
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rd_val;
    logic             c_regwr, c_memr, c_memwr, c_ldm;
    logic             is_two, is_branch, br_cond;
    logic             stall;
    logic             accept;
    entry_t           dec_entry;

    assign opcode = instr[WIDTH-1 -: 5];
    assign rs     = instr[WIDTH-6 -: AW];
    assign rd     = instr[WIDTH-6-AW -: AW];

    // Register file next state: single write-back port
    always_comb begin
        regs_d = regs_q;
        if (wb_en) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    // Combinational operand reads, optionally bypassing a same-cycle write-back
    always_comb begin
        rs_val = regs_q[rs];
        rd_val = regs_q[rd];
`ifdef DEC_WB_BYPASS_EN
        if (wb_en && (wb_addr == rs)) rs_val = wb_data;
        if (wb_en && (wb_addr == rd)) rd_val = wb_data;
`else
`endif
    end

    // Opcode class decode into control bits and branch condition
    always_comb begin
        c_regwr   = 1'b0;
        c_memr    = 1'b0;
        c_memwr   = 1'b0;
        c_ldm     = 1'b0;
        is_two    = 1'b0;
        is_branch = 1'b0;
        br_cond   = 1'b0;
        case (opcode[4:3])
            2'b00: c_regwr = (opcode != 5'b00000);
            2'b01: begin
                is_two  = 1'b1;
                c_regwr = 1'b1;
                c_ldm   = (opcode == 5'b01000);
            end
            2'b10: begin
                if (opcode == 5'b10000) begin
                    c_memr  = 1'b1;
                    c_regwr = 1'b1;
                end else if (opcode == 5'b10001) begin
                    c_memwr = 1'b1;
                end
            end
            default: begin
                is_branch = 1'b1;
                case (opcode[1:0])
                    2'b00:   br_cond = ccr[0];
                    2'b01:   br_cond = ccr[1];
                    2'b10:   br_cond = ccr[2];
                    default: br_cond = 1'b1;
                endcase
            end
        endcase
    end

    // Handshake: stall holds the word in fetch while a load targets rs or rd
    always_comb begin
        stall = ex_load_pending && ((ex_load_rd == rs) || (ex_load_rd == rd))
                && (state_q == S_DECODE) && in_valid;
        if (state_q == S_FLUSH) begin
            in_ready = 1'b1;
        end else begin
            in_ready = (!out_valid_q || out_ready) && !stall;
        end
        accept = in_valid && in_ready;
    end

    // Entry built from the word currently presented by fetch
    always_comb begin
        dec_entry       = '0;
        dec_entry.op1   = rs_val;
        dec_entry.op2   = rd_val;
        dec_entry.rs    = rs;
        dec_entry.rd    = rd;
        dec_entry.aluop = opcode;
        dec_entry.regwr = c_regwr;
        dec_entry.memr  = c_memr;
        dec_entry.memwr = c_memwr;
        dec_entry.ldm   = c_ldm;
        dec_entry.pc    = in_pc;
    end

    // Sequencing FSM and ID/EX next state; ext_flush overrides everything but rst
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ent_d       = ent_q;
        pend_d      = pend_q;
        out_valid_d = out_valid_q && !out_ready;
        br_taken_d  = 1'b0;
        br_target_d = br_target_q;
        if (ext_flush) begin
            out_valid_d = 1'b0;
            state_d     = S_DECODE;
            cnt_d       = '0;
        end else begin
            case (state_q)
                S_DECODE: begin
                    if (accept) begin
                        if (is_branch) begin
                            if (br_cond) begin
                                br_taken_d  = 1'b1;
                                br_target_d = PCW'(rd_val);
                                state_d     = S_FLUSH;
                                cnt_d       = '0;
                            end
                        end else if (is_two) begin
                            pend_d  = dec_entry;
                            state_d = S_IMM_WAIT;
                        end else begin
                            ent_d       = dec_entry;
                            out_valid_d = 1'b1;
                        end
                    end
                end
                S_IMM_WAIT: begin
                    if (accept) begin
                        ent_d       = pend_q;
                        ent_d.imm   = instr;
                        out_valid_d = 1'b1;
                        state_d     = S_DECODE;
                    end
                end
                S_FLUSH: begin
                    if (accept) begin
                        if (cnt_q == CW'(FLUSH_CYCLES - 1)) begin
                            cnt_d   = '0;
                            state_d = S_DECODE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_DECODE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, ID/EX and register file flops with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_DECODE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            ent_q       <= '0;
            pend_q      <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            ent_q       <= ent_d;
            pend_q      <= pend_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
            regs_q      <= regs_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_op1       = ent_q.op1;
    assign out_op2       = ent_q.op2;
    assign out_imm       = ent_q.imm;
    assign out_rs        = ent_q.rs;
    assign out_rd        = ent_q.rd;
    assign out_aluop     = ent_q.aluop;
    assign out_regwr     = ent_q.regwr;
    assign out_memr      = ent_q.memr;
    assign out_memwr     = ent_q.memwr;
    assign out_ldm       = ent_q.ldm;
    assign out_pc        = ent_q.pc;
    assign branch_taken  = br_taken_q;
    assign branch_target = br_target_q;

endmodule
